// File: rtl/alu_seq_pkg.sv
// Shared opcodes, mul/div FSM states and opcode helpers for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_JR    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {IDLE, RUN, FIN} md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring divide on operand magnitudes, one step per cycle,
// with sign correction applied combinationally while in FIN.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e        state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, q, dv;
  logic             neg_p, neg_r, op_div, dz;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum, rsh;
  logic             ge;
  logic [WIDTH-1:0] acc_step, q_step;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // mul: {acc,q} shifts right with acc accumulating; div: {acc,q} shifts left, quotient bits enter q
  always_comb begin
    msum = {1'b0, acc} + (q[0] ? {1'b0, dv} : '0);
    rsh  = {acc, q[WIDTH-1]};
    ge   = rsh >= {1'b0, dv};
    if (op_div) begin
      acc_step = ge ? rsh[WIDTH-1:0] - dv : rsh[WIDTH-1:0];
      q_step   = {q[WIDTH-2:0], ge};
    end else begin
      acc_step = msum[WIDTH:1];
      q_step   = {msum[0], q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == CW'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      q      <= '0;
      dv     <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      op_div <= 1'b0;
      dz     <= 1'b0;
    end else if (state == IDLE && start) begin
      count  <= CW'(WIDTH);
      acc    <= '0;
      q      <= is_div ? a_mag : b_mag;
      dv     <= is_div ? b_mag : a_mag;
      neg_p  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      op_div <= is_div;
      dz     <= is_div && (b == '0);
    end else if (state == RUN) begin
      count <= count - CW'(1);
      acc   <= acc_step;
      q     <= q_step;
    end
  end

  always_comb begin
    prod     = {acc, q};
    prod_s   = neg_p ? -prod : prod;
    busy     = state != IDLE;
    done     = state == FIN;
    div_zero = done & dz;
    if (op_div) begin
      lo = dz ? '1 : (neg_p ? -q : q);
      hi = neg_r ? -acc : acc;
    end else begin
      hi = prod_s[2*WIDTH-1:WIDTH];
      lo = prod_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle ops plus iterative mul/div into HI/LO,
// behind a valid/ready handshake that drops ready while mul/div runs.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       ALUCtr,
  output logic             res_valid,
  output logic [WIDTH-1:0] ALURes,
  output logic             zero,
  output logic             busy,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic             accept, md_start, md_busy, md_done, md_dz;
  logic [WIDTH-1:0] md_hi, md_lo, alu_r;

  assign busy     = md_busy;
  assign in_ready = !md_busy;
  assign accept   = in_valid & in_ready;
  assign md_start = accept & is_muldiv(ALUCtr);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (Clk),
    .rst      (reset),
    .start    (md_start),
    .is_signed(ALUCtr[0]),
    .is_div   (ALUCtr[1]),
    .a        (input1),
    .b        (input2),
    .busy     (md_busy),
    .done     (md_done),
    .hi       (md_hi),
    .lo       (md_lo),
    .div_zero (md_dz)
  );

  always_comb begin
    alu_r = '0;
    case (ALUCtr)
      OP_AND:  alu_r = input1 & input2;
      OP_OR:   alu_r = input1 | input2;
      OP_ADD:  alu_r = input1 + input2;
      OP_SUB:  alu_r = input1 - input2;
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
      OP_NOR:  alu_r = ~(input1 | input2);
      OP_SLL:  alu_r = input1 << input2[SHW-1:0];
      OP_SRL:  alu_r = input1 >> input2[SHW-1:0];
      OP_MFHI: alu_r = hi;
      OP_MFLO: alu_r = lo;
      OP_JR, OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: alu_r = '0;
      default: alu_r = '0;
    endcase
  end

  // md_done and a new accept never coincide: ready is low through FIN
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ALURes    <= '0;
      zero      <= 1'b1;
      res_valid <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      res_valid <= 1'b0;
      div_zero  <= 1'b0;
      if (md_done) begin
        hi        <= md_hi;
        lo        <= md_lo;
        ALURes    <= md_lo;
        zero      <= md_lo == '0;
        res_valid <= 1'b1;
        div_zero  <= md_dz;
      end else if (accept && !is_muldiv(ALUCtr)) begin
        ALURes    <= alu_r;
        zero      <= alu_r == '0;
        res_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal cases plus random traffic
// compared every cycle against a cycle-level arithmetic model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] input1 = '0;
  logic [W-1:0] input2 = '0;
  logic [3:0]   ALUCtr = '0;
  logic         in_ready, res_valid, zero, busy, div_zero;
  logic [W-1:0] ALURes, hi, lo;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input1(input1), .input2(input2), .ALUCtr(ALUCtr), .res_valid(res_valid),
    .ALURes(ALURes), .zero(zero), .busy(busy), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] single_ref(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] h,
                                              input logic [W-1:0] l);
    int sh;
    sh = int'(b % W);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      OP_NOR:  return ~(a | b);
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_MFHI: return h;
      OP_MFLO: return l;
      default: return '0;
    endcase
  endfunction

  // returns {div_zero, hi, lo}
  function automatic logic [2*W:0] md_ref(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [63:0] p;
    longint      sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      OP_MULT:  begin p = sa * sb; return {1'b0, p}; end
      OP_DIVU: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, rr[31:0], qq[31:0]};
      end
    endcase
  endfunction

  // Reference model: tracks accepted requests and when their results are due
  int           cyc = 0;
  int           m_done_cyc = 0;
  bit           m_pending = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_dz = 1'b0;
  bit           m_ndz = 1'b0;
  logic [W-1:0] m_res = '0, m_hi = '0, m_lo = '0, m_nhi = '0, m_nlo = '0;

  always @(posedge Clk or posedge reset) begin
    logic [2*W:0] r;
    if (reset) begin
      cyc = 0; m_pending = 0; m_valid = 0; m_dz = 0;
      m_res = '0; m_hi = '0; m_lo = '0;
    end else begin
      cyc++;
      m_valid = 0;
      m_dz = 0;
      if (m_pending) begin
        if (cyc == m_done_cyc) begin
          m_hi = m_nhi; m_lo = m_nlo; m_res = m_nlo;
          m_dz = m_ndz; m_valid = 1; m_pending = 0;
        end
      end else if (in_valid) begin
        if (ALUCtr inside {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV}) begin
          r = md_ref(ALUCtr, input1, input2);
          m_ndz = r[2*W]; m_nhi = r[2*W-1:W]; m_nlo = r[W-1:0];
          m_pending = 1;
          m_done_cyc = cyc + W + 1;
        end else begin
          m_res = single_ref(ALUCtr, input1, input2, m_hi, m_lo);
          m_valid = 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en && !reset) begin
      check("res_valid", res_valid, m_valid);
      check("busy", busy, m_pending);
      check("in_ready", in_ready, !m_pending);
      check("ALURes", ALURes, m_res);
      check("zero", zero, m_res == '0);
      check("div_zero", div_zero, m_dz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge Clk); n++; end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL issue_ready: in_ready got 0 expected 1 after 100 cycles");
    end
    ALUCtr = op; input1 = a; input2 = b; in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int bc);
    int n = 0;
    bc = 0;
    while (!res_valid && n < 100) begin
      if (!in_ready) bc++;
      @(negedge Clk);
      n++;
    end
    if (!res_valid) begin
      n_vec++; n_err++;
      $display("FAIL wait_result: res_valid got 0 expected 1 within 100 cycles");
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ALURes"}, ALURes, 0);
    check({tag, "_zero"}, zero, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_div_zero"}, div_zero, 0);
    check({tag, "_hi"}, hi, 0);
    check({tag, "_lo"}, lo, 0);
  endtask

  initial begin
    int bc;
    int pulses;
    int n;

    #2 reset = 1'b1;
    #1 check_reset_state("por");
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // streaming back-to-back add then sub
    ALUCtr = OP_ADD; input1 = 5; input2 = 7; in_valid = 1'b1;
    @(negedge Clk);
    check("add_res", ALURes, 32'h0000_000C);
    check("add_zero", zero, 0);
    check("add_valid", res_valid, 1);
    ALUCtr = OP_SUB; input1 = 7; input2 = 7;
    @(negedge Clk);
    in_valid = 1'b0;
    check("sub_res", ALURes, 0);
    check("sub_zero", zero, 1);
    check("sub_valid", res_valid, 1);

    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    check("slt_res", ALURes, 1);
    issue(OP_SLL, 32'h1, 32'h21);
    check("sll_res", ALURes, 32'h0000_0002);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'h7);
    wait_result(bc);
    check("mult_busy_cycles", bc, 33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    check("mult_res", ALURes, 32'hFFFF_FFEB);
    issue(OP_MFHI, 0, 0);
    check("mfhi_res", ALURes, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_result(bc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'h2);
    wait_result(bc);
    check("divu_lo", lo, 32'h7FFF_FFFC);
    check("divu_hi", hi, 32'h0000_0001);

    issue(OP_DIVU, 32'd10, 32'd0);
    wait_result(bc);
    check("dz_busy_cycles", bc, 33);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 32'h0000_000A);
    check("dz_flag", div_zero, 1);
    @(negedge Clk);
    check("dz_flag_drop", div_zero, 0);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(bc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);
    check("ovf_flag", div_zero, 0);

    // add held valid across a mult: accepted only after the mult completes
    ALUCtr = OP_MULT; input1 = 32'hFFFF_FFFD; input2 = 32'h7; in_valid = 1'b1;
    @(negedge Clk);
    ALUCtr = OP_ADD; input1 = 32'h1; input2 = 32'h2;
    n = 0;
    while (!res_valid && n < 100) begin @(negedge Clk); n++; end
    check("hold_mult_res", ALURes, 32'hFFFF_FFEB);
    @(negedge Clk);
    in_valid = 1'b0;
    check("hold_add_valid", res_valid, 1);
    check("hold_add_res", ALURes, 32'h0000_0003);
    pulses = 0;
    repeat (5) begin @(negedge Clk); if (res_valid) pulses++; end
    check("hold_extra_pulses", pulses, 0);

    // reset about 10 cycles into a mult
    issue(OP_MULT, 32'h3, 32'h5);
    repeat (9) @(negedge Clk);
    #2 reset = 1'b1;
    #1 check_reset_state("abort");
    @(negedge Clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin @(negedge Clk); if (res_valid) pulses++; end
    check("abort_pulses", pulses, 0);

    // random traffic, in_valid often held while busy
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      ALUCtr   = 4'($urandom_range(0, 15));
      input1   = rnd_val();
      input2   = rnd_val();
      @(negedge Clk);
    end
    in_valid = 1'b0;
    repeat (40) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU: same op set (and/or/add/sub/slt/nor/sll/srl/jr) at generic WIDTH.
- Adds iterative multiply/divide (signed and unsigned) that writes internal HI/LO registers, plus mfhi/mflo reads.
- Sits in the EX stage behind a valid/ready handshake; the pipeline stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width (>=8, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; equals !busy.
- input1  in  WIDTH  operand A / dividend / multiplicand.
- input2  in  WIDTH  operand B / divisor / multiplier / shift amount.
- ALUCtr  in  4  opcode.
- res_valid  out  1  one-cycle pulse: ALURes/zero/flags valid.
- ALURes  out  WIDTH  registered result.
- zero  out  1  registered, (ALURes==0).
- busy  out  1  mul/div iteration in progress.
- div_zero  out  1  registered with res_valid; divide with input2==0.
- hi, lo  out  WIDTH  current HI/LO contents.

Behaviour:
- Reset (async, immediate): ALURes=0, zero=1, res_valid=0, busy=0, div_zero=0, HI=LO=0. In-flight mul/div is aborted with no result pulse.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. With in_ready low, in_valid is ignored; nothing is queued.
- Opcodes:
  - 0000 and, 0001 or, 0010 add, 0110 sub: wrap modulo 2^WIDTH.
  - 0111 slt: signed compare; result 1/0.
  - 1100 nor.
  - 0011 sll, 0100 srl: shift by input2[SHW-1:0].
  - 0101 jr: result 0.
  - 1000 multu, 1001 mult, 1010 divu, 1011 div.
  - 1101 mfhi, 1110 mflo.
  - Any other code: result 0.
- Single-cycle ops (everything except 1000-1011): accept at edge T, so ALURes/zero/res_valid are visible after edge T, pulse width one cycle. Back-to-back accepts are allowed every cycle.
- mfhi/mflo return HI/LO as of edge T, i.e. including a mul/div that completed at or before T.
- Mul/div FSM states:
  - IDLE: on accept of 1000-1011, go to RUN. Latch operand magnitudes (negate negative operands when signed), the result signs, and count=WIDTH. busy=1, in_ready=0.
  - RUN: one shift-add (mul) or restoring subtract-shift (div) step per cycle; count decrements. When count reaches 0, go to FIN.
  - FIN: apply sign correction, write HI/LO, pulse res_valid, return to IDLE (busy=0).
  - Total: accept at T, HI/LO and res_valid at edge T+WIDTH+1.
- Mul/div results:
  - Multiply: {HI,LO} = full 2*WIDTH-bit product.
  - Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - ALURes = LO; zero = (LO==0).
- Divide by zero: takes no fast path (still WIDTH+1 cycles). LO = all ones, HI = dividend, div_zero=1.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0, no flag.
- Between pulses, ALURes/zero hold their last values; res_valid=0; div_zero=0 except on a divide-by-zero pulse.

Decomposition:
- Package alu_seq_pkg holds:
  - 4-bit opcode localparams (OP_AND … OP_MFLO);
  - FSM state enum (IDLE/RUN/FIN);
  - helper function is_muldiv(op).
- One sub-module, alu_muldiv_iter: WIDTH-parametrised iterative mul/div datapath with start/done, operands, and signed/is_div controls, producing hi/lo/div_zero.
- Top level owns the single-cycle ops, the handshake, the HI/LO registers and output registration.

Test Plan (WIDTH=32):
- Assert reset mid-cycle, then release -> outputs immediately 0/zero=1/res_valid=0/busy=0/HI=LO=0. Reset asserted 10 cycles into a mult -> busy=0 at once, HI/LO=0, no res_valid pulse.
- Streaming single-cycle ops:
  - add 5+7 -> ALURes=0x0000000C, zero=0, one cycle after accept.
  - then sub 7-7 -> 0, zero=1, next cycle.
  - slt 0xFFFFFFFF vs 1 -> 1.
  - sll 1 by 0x21 -> 0x00000002.
- mult: 0xFFFFFFFD * 7 -> in_ready low for 33 cycles. At T+33: HI=0xFFFFFFFF, LO=0xFFFFFFEB, res_valid pulse. A following mfhi returns 0xFFFFFFFF.
- div: 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu of the same operands -> LO=0x7FFFFFFC, HI=1.
- divu 10/0 -> LO=0xFFFFFFFF, HI=0x0000000A, div_zero=1 for one cycle. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- in_valid held high with add during a mult -> not accepted until the cycle after the mult's res_valid; exactly one add result is produced.
